param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter.sv | 50 +++++
 tb/tb_param_updown_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// param_updown_counter: modulo-N up/down counter with 163-style controls; optional sticky wrap flag OVF under PARAM_COUNTER_OVF_EN
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_L,
  input  logic             LD_L,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
`ifdef PARAM_COUNTER_OVF_EN
  ,
  output logic             OVF
`endif
);
  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad
    $error("param_updown_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic             tc, wrap, cnt;
  logic [WIDTH-1:0] nxt;
  // terminal count, wrap detection (includes out-of-range loaded values) and next count value
  always_comb begin
    tc   = UP ? (Q == MAX) : (Q == '0);
    wrap = UP ? (Q >= MAX) : (Q == '0 || Q > MAX);
    cnt  = ENP & ENT;
    nxt  = wrap ? (UP ? '0 : MAX) : (UP ? Q + 1'b1 : Q - 1'b1);
    RCO  = ENT & tc;
  end
  // counter register: clear beats load beats count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Q <= '0;
    else if (!CLR_L) Q <= '0;
    else if (!LD_L) Q <= D;
    else if (cnt) Q <= nxt;
  end
`ifdef PARAM_COUNTER_OVF_EN
  // sticky wrap flag: set on any counting wrap, cleared only by reset or clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) OVF <= 1'b0;
    else if (!CLR_L) OVF <= 1'b0;
    else if (LD_L && cnt && wrap) OVF <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed checks of modulo-10 counter and a two-stage modulo-16 cascade
module tb_param_updown_counter;
  logic       clk = 1'b0;
  logic       rst, clr_l, ld_l, enp, ent, up;
  logic [3:0] d, q, q0, q1, d0, d1;
  logic       rco, rco0, rco1, cld_l, cenp;
  int checks = 0;
  int errors = 0;
`ifdef PARAM_COUNTER_OVF_EN
  logic ovf, ovf0, ovf1;
`endif

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(clk), .RST(rst), .CLR_L(clr_l), .LD_L(ld_l), .ENP(enp), .ENT(ent), .UP(up),
    .D(d), .Q(q), .RCO(rco)
`ifdef PARAM_COUNTER_OVF_EN
    , .OVF(ovf)
`endif
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(16)) c0 (
    .CLK(clk), .RST(rst), .CLR_L(1'b1), .LD_L(cld_l), .ENP(cenp), .ENT(1'b1), .UP(1'b1),
    .D(d0), .Q(q0), .RCO(rco0)
`ifdef PARAM_COUNTER_OVF_EN
    , .OVF(ovf0)
`endif
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(16)) c1 (
    .CLK(clk), .RST(rst), .CLR_L(1'b1), .LD_L(cld_l), .ENP(cenp), .ENT(rco0), .UP(1'b1),
    .D(d1), .Q(q1), .RCO(rco1)
`ifdef PARAM_COUNTER_OVF_EN
    , .OVF(ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ovf_chk(input string tag, input logic exp);
`ifdef PARAM_COUNTER_OVF_EN
    chk(tag, ovf, exp);
`endif
  endtask

  initial begin
    rst = 1'b1; clr_l = 1'b1; ld_l = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1; d = '0;
    cld_l = 1'b1; cenp = 1'b0; d0 = '0; d1 = '0;
    tick(); tick();
    chk("reset_q", q, 0);
    chk("reset_rco", rco, 0);
    ovf_chk("reset_ovf", 1'b0);
    rst = 1'b0;
    enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) ovf_chk("ovf_before_wrap", 1'b0);
      tick();
      chk($sformatf("up_q_%0d", i), q, i % 10);
      chk($sformatf("up_rco_%0d", i), rco, (i % 10) == 9);
    end
    ovf_chk("ovf_after_wrap", 1'b1);
    for (int i = 0; i < 9; i++) tick();
    chk("up_q_9_again", q, 9);
    ent = 1'b0; #1;
    chk("rco_ent0", rco, 0);
    ent = 1'b1; #1;
    chk("rco_ent1", rco, 1);
    tick(); tick(); tick();
    chk("pre_rst_q", q, 2);
    #2 rst = 1'b1; #1;
    chk("async_rst_q", q, 0);
    ovf_chk("async_rst_ovf", 1'b0);
    tick(); tick();
    chk("rst_hold_q", q, 0);
    rst = 1'b0;
    ld_l = 1'b0; d = 4'd3; enp = 1'b0; ent = 1'b0;
    tick();
    chk("load3", q, 3);
    ld_l = 1'b1; up = 1'b0; enp = 1'b1; ent = 1'b1;
    tick(); chk("dn_2", q, 2);
    tick(); chk("dn_1", q, 1);
    chk("dn_rco_1", rco, 0);
    tick(); chk("dn_0", q, 0);
    chk("dn_rco_0", rco, 1);
    ovf_chk("dn_ovf_before", 1'b0);
    tick(); chk("dn_9", q, 9);
    chk("dn_rco_9", rco, 0);
    ovf_chk("dn_ovf_after", 1'b1);
    ld_l = 1'b0; d = 4'd12; enp = 1'b0;
    tick(); chk("load12", q, 12);
    ovf_chk("load_keeps_ovf", 1'b1);
    ld_l = 1'b1; enp = 1'b1;
    tick(); chk("dn_from_12", q, 9);
    ld_l = 1'b0; enp = 1'b0;
    tick(); chk("load12_b", q, 12);
    ld_l = 1'b1; up = 1'b1; enp = 1'b1;
    tick(); chk("up_from_12", q, 0);
    clr_l = 1'b0; ld_l = 1'b0; d = 4'd5;
    tick(); chk("clr_beats_ld", q, 0);
    ovf_chk("clr_ovf", 1'b0);
    clr_l = 1'b1;
    tick(); chk("ld_beats_cnt", q, 5);
    ld_l = 1'b1; enp = 1'b0; ent = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); chk("hold_enp0", q, 5); end
    enp = 1'b1; ent = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk("hold_ent0", q, 5); end
    ent = 1'b1; up = 1'b0; #1;
    chk("rco_up_change", rco, 0);
    tick(); chk("dir_change", q, 4);
    up = 1'b1; ld_l = 1'b0; d = 4'd9;
    tick(); chk("load9", q, 9);
    ld_l = 1'b1;
    tick(); chk("wrap_after_load9", q, 0);
    ovf_chk("ovf_load9_wrap", 1'b1);
    ld_l = 1'b0;
    tick(); chk("load9_b", q, 9);
    ld_l = 1'b1; clr_l = 1'b0;
    tick(); chk("clr_beats_wrap", q, 0);
    ovf_chk("clr_wrap_no_ovf", 1'b0);
    clr_l = 1'b1; enp = 1'b0;
    cld_l = 1'b0; d1 = 4'h0; d0 = 4'hE;
    tick(); chk("casc_load0e", {q1, q0}, 8'h0E);
    cld_l = 1'b1; cenp = 1'b1;
    tick(); chk("casc_0f", {q1, q0}, 8'h0F);
    chk("casc_rco0_0f", rco0, 1);
    tick(); chk("casc_10", {q1, q0}, 8'h10);
    tick(); chk("casc_11", {q1, q0}, 8'h11);
    cld_l = 1'b0; d1 = 4'hF; d0 = 4'hD;
    tick(); chk("casc_loadfd", {q1, q0}, 8'hFD);
    cld_l = 1'b1;
    tick(); chk("casc_fe", {q1, q0}, 8'hFE);
    chk("casc_rco1_fe", rco1, 0);
    tick(); chk("casc_ff", {q1, q0}, 8'hFF);
    chk("casc_rco1_ff", rco1, 1);
    tick(); chk("casc_00", {q1, q0}, 8'h00);
    cenp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
